fwd_operand_stage: RTL

- Parametrised successor to the fixed 3:1 forwarding operand mux; it sits at the ID/EX boundary of the 5-stage pipeline.
- For both source operands (rs1, rs2) it does three things:
  - compares register addresses against NUM_FWD in-flight producers;
  - selects the youngest matching result, or the register-file value;
  - detects load-use hazards.
- Results are registered into the EX-stage operand register, with stall/flush control and a saturating forward-event counter.

---
 rtl/fwd_operand_stage_if.sv | 54 +++++
 rtl/fwd_operand_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fwd_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_operand_stage_if
// Purpose  : ID-stage operand request, forwarding sources, and EX-stage
//            operand register outputs for fwd_operand_stage.
// Revision : 1.0  initial release
// ============================================================================
interface fwd_operand_stage_if #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1),
    parameter int CNT_W   = 16
);
    // ID-stage request
    logic                      id_valid;
    logic [REG_AW-1:0]         rs1_addr;
    logic [REG_AW-1:0]         rs2_addr;
    logic [XLEN-1:0]           rs1_rf;
    logic [XLEN-1:0]           rs2_rf;
    // In-flight producers, index 0 youngest
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic [NUM_FWD-1:0]        fwd_pending;
    // Pipeline control
    logic                      ex_stall;
    logic                      flush;
    logic                      id_stall;
    // EX-stage operand register
    logic                      ex_valid;
    logic [XLEN-1:0]           ex_op1;
    logic [XLEN-1:0]           ex_op2;
    logic [SEL_W-1:0]          ex_sel1;
    logic [SEL_W-1:0]          ex_sel2;
    logic [CNT_W-1:0]          fwd_count;

    // Driver side: the pipeline feeding ID and observing EX
    modport master (
        output id_valid, rs1_addr, rs2_addr, rs1_rf, rs2_rf,
        output fwd_valid, fwd_rd, fwd_data, fwd_pending,
        output ex_stall, flush,
        input  id_stall, ex_valid, ex_op1, ex_op2, ex_sel1, ex_sel2, fwd_count
    );

    // Operand stage side
    modport slave (
        input  id_valid, rs1_addr, rs2_addr, rs1_rf, rs2_rf,
        input  fwd_valid, fwd_rd, fwd_data, fwd_pending,
        input  ex_stall, flush,
        output id_stall, ex_valid, ex_op1, ex_op2, ex_sel1, ex_sel2, fwd_count
    );
endinterface
`default_nettype wire

// File: rtl/fwd_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : fwd_operand_stage
// Purpose  : ID/EX operand forwarding. Picks the youngest matching in-flight
//            result (or the register file) for rs1/rs2, detects load-use
//            hazards, and registers the operand pair into EX with
//            stall/flush control and a saturating forward-event counter.
// Revision : 1.0  initial release
// ============================================================================
module fwd_operand_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1),
    parameter int CNT_W   = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    fwd_operand_stage_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [NUM_FWD-1:0] w_m1;
    logic [NUM_FWD-1:0] w_m2;
    logic [XLEN-1:0]    w_op1;
    logic [XLEN-1:0]    w_op2;
    logic [SEL_W-1:0]   w_sel1;
    logic [SEL_W-1:0]   w_sel2;
    logic               w_pend1;
    logic               w_pend2;
    logic               w_hazard;
    logic [1:0]         w_inc;
    logic [CNT_W:0]     w_cnt_sum;
    logic [CNT_W-1:0]   w_cnt_next;

    logic               r_valid;
    logic [XLEN-1:0]    r_op1;
    logic [XLEN-1:0]    r_op2;
    logic [SEL_W-1:0]   r_sel1;
    logic [SEL_W-1:0]   r_sel2;
    logic [CNT_W-1:0]   r_cnt;

    // Per-source address compare; x0 never matches so it always reads as 0
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign w_m1[gi] = bus.fwd_valid[gi]
                           && (bus.fwd_rd[gi*REG_AW +: REG_AW] == bus.rs1_addr)
                           && (bus.rs1_addr != '0);
            assign w_m2[gi] = bus.fwd_valid[gi]
                           && (bus.fwd_rd[gi*REG_AW +: REG_AW] == bus.rs2_addr)
                           && (bus.rs2_addr != '0);
        end
    endgenerate

    // Priority select: scan oldest to youngest so the lowest index wins
    always_comb begin
        w_op1   = bus.rs1_rf;
        w_op2   = bus.rs2_rf;
        w_sel1  = '0;
        w_sel2  = '0;
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_m1[i]) begin
                w_op1   = bus.fwd_data[i*XLEN +: XLEN];
                w_sel1  = SEL_W'(i + 1);
                w_pend1 = bus.fwd_pending[i];
            end
            if (w_m2[i]) begin
                w_op2   = bus.fwd_data[i*XLEN +: XLEN];
                w_sel2  = SEL_W'(i + 1);
                w_pend2 = bus.fwd_pending[i];
            end
        end
        if (bus.rs1_addr == '0) begin
            w_op1 = '0;
        end
        if (bus.rs2_addr == '0) begin
            w_op2 = '0;
        end
    end

    // Only a pending winner stalls; a pending older source hidden by a
    // younger ready match is harmless
    assign w_hazard     = bus.id_valid && (w_pend1 || w_pend2);
    assign bus.id_stall = w_hazard || bus.ex_stall;

    // Saturating add of the number of forwarded operands this cycle
    assign w_inc      = {1'b0, (w_sel1 != '0)} + {1'b0, (w_sel2 != '0)};
    assign w_cnt_sum  = {1'b0, r_cnt} + (CNT_W + 1)'(w_inc);
    assign w_cnt_next = (w_cnt_sum > {1'b0, c_cnt_max}) ? c_cnt_max
                                                        : w_cnt_sum[CNT_W-1:0];

    // EX operand register: reset > flush > hold > bubble > capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_sel1  <= '0;
            r_sel2  <= '0;
            r_cnt   <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_sel1  <= '0;
            r_sel2  <= '0;
        end else if (bus.ex_stall) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.id_valid;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_sel1  <= w_sel1;
            r_sel2  <= w_sel2;
            if (bus.id_valid) begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign bus.ex_valid  = r_valid;
    assign bus.ex_op1    = r_op1;
    assign bus.ex_op2    = r_op2;
    assign bus.ex_sel1   = r_sel1;
    assign bus.ex_sel2   = r_sel2;
    assign bus.fwd_count = r_cnt;

endmodule
`default_nettype wire
